out_accum_stage: RTL and testbench
==================================

# out_accum_stage

Output-accumulation stage between the MAC array row drain and the write buffer. It accepts one 64-bit result row per handshake (4 lanes × 16-bit signed). In accumulate mode it reads the prior partial sum for that row from output memory and adds it lane-wise with saturation. It then presents the row to the write buffer as a one-cycle `OMWrite_om` pulse carrying `ODST_om` and `DACC`.

## Interface
Parameters:
- `LANES`, 4: lanes per row.
- `LW`, 16: lane width in bits. Row width is `LANES*LW` = 64.

Ports:
- `CLK`, in, 1: single clock. All logic is on the rising edge.
- `RSTN`, in, 1: reset. Synchronous, active-low; sampled on the rising edge of `CLK`.
- `CLR_DP`, in, 1: synchronous datapath clear; drops rows in flight.
- `ACC_ctrl`, in, 1: sampled per accepted row. 1 = accumulate with memory, 0 = pass through.
- `ROW_VALID`, in, 1: row offered by the MAC array.
- `ROW_READY`, out, 1: row accepted when `ROW_VALID && ROW_READY` at a rising edge.
- `ROW_DST`, in, 4: output-memory row address.
- `ROW_DATA`, in, 64: new partial sums. Lane k occupies bits [16k+15:16k].
- `OM_REN`, out, 1: output-memory read enable (combinational).
- `OM_RADDR`, out, 4: output-memory read address (combinational, equals `ROW_DST`).
- `OM_RDATA`, in, 64: read data, valid exactly one cycle after `OM_REN`.
- `OUT_STALL`, in, 1: downstream cannot take a row this cycle (write buffer not collecting).
- `OMWrite_om`, out, 1: one cycle per row; result valid.
- `ODST_om`, out, 4: destination row of the result.
- `DACC`, out, 64: accumulated row.
- `SAT_FLAG`, out, 1: sticky; set when any lane has saturated since the last reset or `CLR_DP`.

## Operation
- Two pipeline registers:
  - S1: `v1`, dst, data, acc bit, `rd_fresh` bit, `old` holding register.
  - S2 (output): `v2`, `ODST_om`, `DACC`.
- `stall = v2 && OUT_STALL`.
- `ROW_READY = !CLR_DP && !stall`.
- Accept: load S1 with `v1`=1, `ROW_DST`, `ROW_DATA`, `acc=ACC_ctrl`.
  - `OM_REN = ROW_VALID && ROW_READY && ACC_ctrl`.
  - `rd_fresh` is set to `OM_REN`.
- Read data capture:
  - The cycle after a read, `OM_RDATA` is valid; `old_eff = rd_fresh ? OM_RDATA : old`.
  - `old` is loaded from `OM_RDATA` whenever `rd_fresh` = 1.
  - `rd_fresh` clears after one cycle, so data survives a stall.
- S1→S2 move when `v1 && !stall`:
  - `DACC` = per-lane `sat16(old_eff_k + data_k)` if acc, else `data`.
  - `ODST_om` = dst, `v2` = 1.
  - `v1` becomes 1 only if a new row is accepted the same edge.
- Saturation: compute each lane in 17-bit signed. Results above 32767 → 32767; below −32768 → −32768. Any clamp sets `SAT_FLAG`.
- `OMWrite_om = v2 && !OUT_STALL`.
  - `v2` clears at the edge where `OMWrite_om` = 1, unless S1 refills it on that edge.
- Full throughput: one row per cycle when `OUT_STALL` = 0.
- Rows are emitted in acceptance order. Nothing is dropped or duplicated except by `CLR_DP`/reset.
- Hazard: a new row to the same dst as the row in S1/S2 is not forwarded. The controller guarantees distinct `ROW_DST` within a tile.
- `CLR_DP` (when `RSTN` = 1):
  - Next edge: `v1`, `v2`, `rd_fresh`, `SAT_FLAG` ← 0.
  - `old`, `DACC`, `ODST_om` ← 0.
  - No acceptance that cycle.

## Timing
- Reset (`RSTN` = 0 at an edge):
  - All registers ← 0.
  - After the edge: `ROW_READY`=1 (if `CLR_DP`=0), `OMWrite_om`=0, `ODST_om`=0, `DACC`=0, `SAT_FLAG`=0.
  - `OM_REN`=0 while `RSTN`=0 (gate with `RSTN`).
  - Reset mid-operation discards all in-flight rows.
- Latency, no stall: accept at edge t. `OM_REN` is high in the cycle ending at t; `OM_RDATA` is valid in the cycle ending at t+1. `OMWrite_om` is high in the cycle after edge t+1.
- Back-to-back rows: `OMWrite_om` is high on consecutive cycles.
- `OUT_STALL` high with `v2`=1:
  - `OMWrite_om`=0; `DACC`/`ODST_om` hold; `ROW_READY`=0; S1 holds.
  - On deassert, the held row pulses that cycle; S1 advances on the same edge.
- `OUT_STALL` high with `v2`=0: no effect; S1 may still advance into S2.
- `CLR_DP` and `ROW_VALID` in the same cycle: row not accepted, `OM_REN`=0.
- `CLR_DP` and `OMWrite_om` in the same cycle: the pulse is still visible that cycle; the pipeline clears at the edge.

## Test plan
- Pass-through: reset, `ACC_ctrl`=0, 4 rows dst 0..3, data `0x0004_0003_0002_0001`+k. Required: `OM_REN` never asserted; 4 consecutive `OMWrite_om` pulses, first at accept+2, `DACC` equal to the inputs.
- Accumulate: `OM_RDATA`=`0x0010_0010_0010_0010`, row `0x0001_0002_0003_0004`, `ACC_ctrl`=1, dst 5. Required: `OM_RADDR`=5, `DACC`=`0x0011_0012_0013_0014`, `ODST_om`=5, `SAT_FLAG`=0.
- Saturation: lane0 old=`0x7FF0`, new=`0x0020`; lane1 old=`0x8000`, new=`0xFFFF`. Required: lane0 `0x7FFF`, lane1 `0x8000`, `SAT_FLAG`=1 until `CLR_DP`.
- Stall: accumulate stream of 3 rows, `OUT_STALL` high 5 cycles starting when first result is in S2. Required: `ROW_READY`=0 during stall; `DACC` stable; 2nd row's read data retained; then 3 pulses in order with correct sums.
- `CLR_DP` mid-stream: 2 rows in flight, `CLR_DP` one cycle. Required: no further `OMWrite_om`; `DACC`=0, `SAT_FLAG`=0; next row is processed normally at accept+2.
- Reset mid-stall: `RSTN`=0 one edge while `v2`=1. Required: all outputs return to reset values; `ROW_READY`=1 after `RSTN`=1.

Source files
------------

// File: rtl/out_accum_stage.sv
// Output-accumulation stage: takes one MAC row per handshake, optionally adds the
// prior partial sum read from output memory (lane-wise, saturating), and emits it.
module out_accum_stage #(
  parameter int LANES = 4,
  parameter int LW    = 16
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  CLR_DP,
  input  logic                  ACC_ctrl,
  input  logic                  ROW_VALID,
  output logic                  ROW_READY,
  input  logic [3:0]            ROW_DST,
  input  logic [LANES*LW-1:0]   ROW_DATA,
  output logic                  OM_REN,
  output logic [3:0]            OM_RADDR,
  input  logic [LANES*LW-1:0]   OM_RDATA,
  input  logic                  OUT_STALL,
  output logic                  OMWrite_om,
  output logic [3:0]            ODST_om,
  output logic [LANES*LW-1:0]   DACC,
  output logic                  SAT_FLAG
);

  localparam int RW = LANES * LW;
  localparam logic [LW-1:0] LANE_MAX = {1'b0, {(LW-1){1'b1}}};
  localparam logic [LW-1:0] LANE_MIN = {1'b1, {(LW-1){1'b0}}};

  // S1 stage
  logic          v1;
  logic          acc1;
  logic          rd_fresh;
  logic [3:0]    dst1;
  logic [RW-1:0] data1;
  logic [RW-1:0] old_q;

  // S2 stage (drives the output ports directly)
  logic          v2;

  logic          stall;
  logic          accept;
  logic          advance;
  logic [RW-1:0] old_eff;
  logic [RW-1:0] sum_row;
  logic [LANES-1:0] lane_sat;
  logic          any_sat;

  // Handshake: a row transfers at a rising edge where ROW_VALID && ROW_READY.
  // ROW_READY depends only on CLR_DP and the output stall, never on ROW_VALID.
  assign stall      = v2 && OUT_STALL;
  assign ROW_READY  = !CLR_DP && !stall;
  assign accept     = ROW_VALID && ROW_READY;
  assign OM_REN     = accept && ACC_ctrl && RSTN;
  assign OM_RADDR   = ROW_DST;
  assign advance    = v1 && !stall;
  assign OMWrite_om = v2 && !OUT_STALL;

  // Read data is live only the cycle after the read; afterwards the held copy is used.
  assign old_eff = rd_fresh ? OM_RDATA : old_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic [LW:0]   wide;
    assign a    = old_eff[k*LW +: LW];
    assign b    = data1[k*LW +: LW];
    assign wide = {a[LW-1], a} + {b[LW-1], b};
    // Top two bits disagree exactly when the 17-bit sum leaves the 16-bit range.
    assign lane_sat[k] = wide[LW] ^ wide[LW-1];
    assign sum_row[k*LW +: LW] = lane_sat[k] ? (wide[LW] ? LANE_MIN : LANE_MAX)
                                             : wide[LW-1:0];
  end

  assign any_sat = acc1 && (|lane_sat);

  always_ff @(posedge CLK) begin
    if (!RSTN || CLR_DP) begin
      v1       <= 1'b0;
      acc1     <= 1'b0;
      rd_fresh <= 1'b0;
      dst1     <= '0;
      data1    <= '0;
      old_q    <= '0;
      v2       <= 1'b0;
      ODST_om  <= '0;
      DACC     <= '0;
      SAT_FLAG <= 1'b0;
    end else begin
      rd_fresh <= OM_REN;
      if (rd_fresh) begin
        old_q <= OM_RDATA;
      end

      if (accept) begin
        v1    <= 1'b1;
        dst1  <= ROW_DST;
        data1 <= ROW_DATA;
        acc1  <= ACC_ctrl;
      end else if (advance) begin
        v1 <= 1'b0;
      end

      if (!stall) begin
        v2 <= v1;
        if (v1) begin
          ODST_om <= dst1;
          DACC    <= acc1 ? sum_row : data1;
          if (any_sat) begin
            SAT_FLAG <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_out_accum_stage.sv
// Bench for out_accum_stage: vector table, directed multi-cycle sequences and a
// randomized run checked against a lane-arithmetic reference model.
module tb_out_accum_stage;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        CLR_DP;
  logic        ACC_ctrl;
  logic        ROW_VALID;
  logic        ROW_READY;
  logic [3:0]  ROW_DST;
  logic [63:0] ROW_DATA;
  logic        OM_REN;
  logic [3:0]  OM_RADDR;
  logic [63:0] OM_RDATA;
  logic        OUT_STALL;
  logic        OMWrite_om;
  logic [3:0]  ODST_om;
  logic [63:0] DACC;
  logic        SAT_FLAG;

  out_accum_stage #(.LANES(4), .LW(16)) dut (
    .CLK(CLK), .RSTN(RSTN), .CLR_DP(CLR_DP), .ACC_ctrl(ACC_ctrl),
    .ROW_VALID(ROW_VALID), .ROW_READY(ROW_READY), .ROW_DST(ROW_DST),
    .ROW_DATA(ROW_DATA), .OM_REN(OM_REN), .OM_RADDR(OM_RADDR),
    .OM_RDATA(OM_RDATA), .OUT_STALL(OUT_STALL), .OMWrite_om(OMWrite_om),
    .ODST_om(ODST_om), .DACC(DACC), .SAT_FLAG(SAT_FLAG)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [63:0] mem [16];
  logic [67:0] exp_q[$];
  int pulse_log[$];
  bit model_sat = 1'b0;

  typedef struct {
    bit          acc;
    logic [3:0]  dst;
    logic [63:0] old;
    logic [63:0] data;
    logic [63:0] exp_dacc;
    bit          exp_sat;
  } vec_t;
  vec_t tbl[6];

  // clock / reset
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // output memory: data valid the cycle after a read, garbage otherwise
  always @(posedge CLK) begin
    if (OM_REN) OM_RDATA <= mem[OM_RADDR];
    else        OM_RDATA <= {$urandom(), $urandom()};
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // reference: each lane as plain integers, clamped to the 16-bit signed range
  function automatic logic [63:0] model_row(bit acc, logic [63:0] old, logic [63:0] nw,
                                            output bit sat);
    logic [63:0] r;
    logic signed [15:0] a16, b16;
    int s;
    sat = 1'b0;
    r = nw;
    if (acc) begin
      for (int k = 0; k < 4; k++) begin
        a16 = old[k*16 +: 16];
        b16 = nw[k*16 +: 16];
        s = int'(a16) + int'(b16);
        if (s > 32767) begin s = 32767; sat = 1'b1; end
        else if (s < -32768) begin s = -32768; sat = 1'b1; end
        r[k*16 +: 16] = s[15:0];
      end
    end
    return r;
  endfunction

  function automatic void push_row(bit acc, logic [3:0] dst, logic [63:0] data);
    bit s;
    logic [63:0] r;
    r = model_row(acc, mem[dst], data, s);
    exp_q.push_back({dst, r});
    if (s) model_sat = 1'b1;
  endfunction

  // scoreboard: every write pulse must match the head of the expected queue
  always begin : mon
    logic [67:0] e;
    @(negedge CLK);
    #2;
    if (RSTN) begin
      if (OUT_STALL) check("no_write_while_stall", 64'(OMWrite_om), 64'd0);
      if (OMWrite_om) begin
        pulse_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got dst %0d data %h, required no write", ODST_om, DACC);
        end else begin
          e = exp_q.pop_front();
          check("write_dst", 64'(ODST_om), 64'(e[67:64]));
          check("write_data", DACC, e[63:0]);
        end
      end
    end
  end

  // driver tasks: all start and end just after a falling edge
  task automatic send_row(input bit acc, input logic [3:0] dst, input logic [63:0] data,
                          output int acc_c);
    int w;
    w = 0;
    ROW_VALID = 1'b1;
    ACC_ctrl  = acc;
    ROW_DST   = dst;
    ROW_DATA  = data;
    #1;
    while (!ROW_READY && w < 50) begin
      @(negedge CLK);
      #1;
      w++;
    end
    acc_c = cyc;
    if (!ROW_READY) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: ROW_READY=%b, required 1", ROW_READY);
    end else begin
      check("om_ren", 64'(OM_REN), 64'(acc));
      if (acc) check("om_raddr", 64'(OM_RADDR), 64'(dst));
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    ROW_VALID = 1'b0;
    ACC_ctrl  = 1'b0;
    @(negedge CLK);
  endtask

  task automatic drain(input int max_cyc);
    int w;
    w = 0;
    ROW_VALID = 1'b0;
    while (exp_q.size() > 0 && w < max_cyc) begin
      @(negedge CLK);
      #3;
      w++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d rows still pending, required 0", exp_q.size());
    end
    exp_q.delete();
    @(negedge CLK);
  endtask

  task automatic clr_pulse();
    CLR_DP    = 1'b1;
    ROW_VALID = 1'b0;
    @(posedge CLK);
    exp_q.delete();
    model_sat = 1'b0;
    @(negedge CLK);
    CLR_DP = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    int ac;
    int acs[4];
    logic [63:0] e0;
    bit sdummy;
    bit acc_now, pend;

    tbl[0] = '{1'b0, 4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 1'b0};
    tbl[1] = '{1'b1, 4'd5,  64'h0010_0010_0010_0010, 64'h0001_0002_0003_0004, 64'h0011_0012_0013_0014, 1'b0};
    tbl[2] = '{1'b1, 4'd7,  64'h0000_0000_8000_7FF0, 64'hFFFF_1234_FFFF_0020, 64'hFFFF_1234_8000_7FFF, 1'b1};
    tbl[3] = '{1'b1, 4'd2,  64'h7FFF_8000_0001_FFFF, 64'h8001_7FFF_FFFF_0001, 64'h0000_FFFF_0000_0000, 1'b0};
    tbl[4] = '{1'b1, 4'd9,  64'h4000_C000_7FFF_8000, 64'h4000_C000_0001_FFFF, 64'h7FFF_8000_7FFF_8000, 1'b1};
    tbl[5] = '{1'b0, 4'd15, 64'h1234_5678_9ABC_DEF0, 64'h8000_7FFF_0000_FFFF, 64'h8000_7FFF_0000_FFFF, 1'b0};

    for (int k = 0; k < 16; k++) mem[k] = {$urandom(), $urandom()};
    RSTN = 1'b0; CLR_DP = 1'b0; ACC_ctrl = 1'b1; ROW_VALID = 1'b1;
    ROW_DST = 4'd5; ROW_DATA = '0; OUT_STALL = 1'b0;

    // reset state; OM_REN must stay low while RSTN is low even with a valid row
    repeat (2) @(negedge CLK);
    #1;
    check("reset_om_ren", 64'(OM_REN), 64'd0);
    ROW_VALID = 1'b0;
    RSTN = 1'b1;
    #1;
    check("reset_ready", 64'(ROW_READY), 64'd1);
    check("reset_write", 64'(OMWrite_om), 64'd0);
    check("reset_odst", 64'(ODST_om), 64'd0);
    check("reset_dacc", DACC, 64'd0);
    check("reset_sat", 64'(SAT_FLAG), 64'd0);
    @(negedge CLK);

    // vector table: single rows, latency, result and sticky flag
    for (int i = 0; i < 6; i++) begin
      clr_pulse();
      mem[tbl[i].dst] = tbl[i].old;
      pulse_log.delete();
      send_row(tbl[i].acc, tbl[i].dst, tbl[i].data, ac);
      exp_q.push_back({tbl[i].dst, tbl[i].exp_dacc});
      drain(10);
      check("tbl_sat", 64'(SAT_FLAG), 64'(tbl[i].exp_sat));
      check("tbl_latency", 64'((pulse_log.size() == 1) ? pulse_log[0] - ac : -1), 64'd2);
    end

    // pass-through burst: back-to-back pulses, no memory reads
    clr_pulse();
    pulse_log.delete();
    for (int k = 0; k < 4; k++) begin
      send_row(1'b0, 4'(k), 64'h0004_0003_0002_0001 + 64'(k), acs[k]);
      push_row(1'b0, 4'(k), 64'h0004_0003_0002_0001 + 64'(k));
    end
    drain(10);
    check("pt_pulse_count", 64'(pulse_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < pulse_log.size(); k++)
      check("pt_pulse_cycle", 64'(pulse_log[k]), 64'(acs[k] + 2));

    // stall with three accumulate rows; second row's read data must survive the stall
    clr_pulse();
    mem[8] = 64'h0100_0200_0300_0400; mem[9] = 64'h7FFF_0001_8000_0010; mem[10] = 64'h0005_0006_0007_0008;
    send_row(1'b1, 4'd8, 64'h0001_0001_0001_0001, ac);
    push_row(1'b1, 4'd8, 64'h0001_0001_0001_0001);
    send_row(1'b1, 4'd9, 64'h0002_0003_FFFF_0020, ac);
    push_row(1'b1, 4'd9, 64'h0002_0003_FFFF_0020);
    e0 = model_row(1'b1, mem[8], 64'h0001_0001_0001_0001, sdummy);
    ROW_VALID = 1'b1; ACC_ctrl = 1'b1; ROW_DST = 4'd10; ROW_DATA = 64'h0010_0020_0030_0040;
    OUT_STALL = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_ready", 64'(ROW_READY), 64'd0);
      check("stall_om_ren", 64'(OM_REN), 64'd0);
      check("stall_dacc_hold", DACC, e0);
      check("stall_odst_hold", 64'(ODST_om), 64'd8);
      @(negedge CLK);
    end
    OUT_STALL = 1'b0;
    pulse_log.delete();
    send_row(1'b1, 4'd10, 64'h0010_0020_0030_0040, ac);
    push_row(1'b1, 4'd10, 64'h0010_0020_0030_0040);
    drain(10);
    check("stall_pulse_count", 64'(pulse_log.size()), 64'd3);
    if (pulse_log.size() == 3) begin
      check("stall_pulse_gap1", 64'(pulse_log[1] - pulse_log[0]), 64'd1);
      check("stall_pulse_gap2", 64'(pulse_log[2] - pulse_log[1]), 64'd1);
    end

    // CLR_DP with two rows in flight: the visible pulse still lands, the rest is dropped
    clr_pulse();
    mem[11] = 64'h0000_0000_0000_7FF0;
    send_row(1'b1, 4'd11, 64'h0000_0000_0000_0020, ac);
    push_row(1'b1, 4'd11, 64'h0000_0000_0000_0020);
    send_row(1'b1, 4'd12, 64'h0001_0001_0001_0001, ac);
    push_row(1'b1, 4'd12, 64'h0001_0001_0001_0001);
    pulse_log.delete();
    CLR_DP = 1'b1; ROW_VALID = 1'b1; ACC_ctrl = 1'b1; ROW_DST = 4'd13;
    #1;
    check("clr_om_ren", 64'(OM_REN), 64'd0);
    check("clr_ready", 64'(ROW_READY), 64'd0);
    check("clr_sat_before", 64'(SAT_FLAG), 64'd1);
    @(posedge CLK);
    exp_q.delete();
    model_sat = 1'b0;
    @(negedge CLK);
    CLR_DP = 1'b0; ROW_VALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("clr_no_write", 64'(OMWrite_om), 64'd0);
      check("clr_dacc", DACC, 64'd0);
      check("clr_sat", 64'(SAT_FLAG), 64'd0);
      @(negedge CLK);
    end
    check("clr_pulses_seen", 64'(pulse_log.size()), 64'd1);
    pulse_log.delete();
    mem[13] = 64'h0001_0002_0003_0004;
    send_row(1'b1, 4'd13, 64'h0010_0010_0010_0010, ac);
    push_row(1'b1, 4'd13, 64'h0010_0010_0010_0010);
    drain(10);
    check("clr_next_latency", 64'((pulse_log.size() == 1) ? pulse_log[0] - ac : -1), 64'd2);

    // reset while the output row is stalled
    mem[14] = 64'h0000_0000_0000_7FFF;
    send_row(1'b1, 4'd14, 64'h0000_0000_0000_0001, ac);
    push_row(1'b1, 4'd14, 64'h0000_0000_0000_0001);
    idle();
    OUT_STALL = 1'b1;
    #1;
    check("rst_stall_sat", 64'(SAT_FLAG), 64'd1);
    RSTN = 1'b0;
    @(posedge CLK);
    exp_q.delete();
    model_sat = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    #1;
    check("rst_ready", 64'(ROW_READY), 64'd1);
    check("rst_write", 64'(OMWrite_om), 64'd0);
    check("rst_odst", 64'(ODST_om), 64'd0);
    check("rst_dacc", DACC, 64'd0);
    check("rst_sat", 64'(SAT_FLAG), 64'd0);
    OUT_STALL = 1'b0;
    pulse_log.delete();
    repeat (3) @(negedge CLK);
    check("rst_no_pulses", 64'(pulse_log.size()), 64'd0);

    // randomized traffic with stalls and occasional clears
    clr_pulse();
    for (int k = 0; k < 16; k++) mem[k] = {$urandom(), $urandom()};
    pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        ROW_VALID = ($urandom_range(0, 9) < 7);
        ACC_ctrl  = 1'($urandom_range(0, 1));
        ROW_DST   = 4'($urandom_range(0, 15));
        ROW_DATA  = {$urandom(), $urandom()};
      end
      OUT_STALL = ($urandom_range(0, 3) == 0);
      CLR_DP    = ($urandom_range(0, 39) == 0);
      #1;
      acc_now = ROW_VALID && ROW_READY;
      check("rand_om_ren", 64'(OM_REN), 64'(acc_now && ACC_ctrl));
      if (OM_REN) check("rand_om_raddr", 64'(OM_RADDR), 64'(ROW_DST));
      if (CLR_DP) check("rand_ready_clr", 64'(ROW_READY), 64'd0);
      @(posedge CLK);
      if (CLR_DP) begin
        exp_q.delete();
        model_sat = 1'b0;
      end else if (acc_now) begin
        push_row(ACC_ctrl, ROW_DST, ROW_DATA);
      end
      pend = ROW_VALID && !acc_now;
      @(negedge CLK);
    end
    CLR_DP = 1'b0;
    OUT_STALL = 1'b0;
    drain(30);
    check("rand_sat_flag", 64'(SAT_FLAG), 64'(model_sat));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
